muldiv_unit: RTL
================

# muldiv_unit

Iterative, parametrised RISC-V M-extension execution unit. It computes all eight MUL/DIV/REM variants selected by `func3` when the ALU decode flags an M-type R-instruction (`func7 = 0000001`). It sits beside the single-cycle ALU in EX and stalls the pipeline through `busy`. It is the multi-cycle successor to single-op MUL support, covering signed/unsigned high products, division and remainder at any `WIDTH`.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 4).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `func3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  `WIDTH`  rs1 operand (multiplicand/dividend).
- `op_b`  in  `WIDTH`  rs2 operand (multiplier/divisor).
- `busy`  out  1  high while in CALC; pipeline stall request.
- `done`  out  1  one-cycle pulse; `result` valid.
- `result`  out  `WIDTH`  registered result, held until the next accepted `start`.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE → CALC on `start` for a normal op.
  - IDLE → DONE on `start` for a special case.
  - CALC → DONE after exactly `WIDTH` iterations.
  - DONE → IDLE unconditionally.
- On accept, latch `func3`, the operand signs and the magnitudes of `op_a`/`op_b`. Take absolute value when the operand is signed for the op:
  - a signed: MULH, MULHSU, DIV, REM.
  - b signed: MULH, DIV, REM.
- Multiply: shift-add, one multiplier bit per cycle, into a 2·`WIDTH` accumulator.
  - MUL returns the low `WIDTH` bits.
  - MULH, MULHSU and MULHU return the high `WIDTH` bits.
- Divide: restoring, one quotient bit per cycle, with a `WIDTH+1`-bit partial remainder.
- Sign fix on the CALC → DONE transition:
  - Negate the full 2·`WIDTH` product when sign_a XOR sign_b, before selecting the high half.
  - Negate the quotient when sign_a XOR sign_b.
  - The remainder takes the sign of the dividend.
- Special cases (signed/unsigned as per op) skip CALC:
  - Divisor 0: quotient = all ones; remainder = `op_a`.
  - Signed overflow (`op_a` = most negative, `op_b` = −1): quotient = `op_a`; remainder = 0.
- `start` while not IDLE (CALC or DONE) is ignored; the operands are not re-sampled.
- All arithmetic is modulo 2^`WIDTH` on output; no overflow flags.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- Normal op:
  - `busy` = 1 in cycles 1..`WIDTH`.
  - `done` = 1 and new `result` in cycle `WIDTH`+1.
  - The next start can be accepted in cycle `WIDTH`+2.
- Special case: `busy` never asserts; `done` and `result` appear in cycle 1.
- `result` updates only on entry to DONE. It is stable in all other cycles.
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, all internal registers 0.
- `rst` asserted in any state (including mid-CALC or in DONE) aborts on the next edge. No `done` is produced for the aborted op. `rst` dominates `start` in the same cycle.

## Structure
- Shared package/header `riscv_m_defs`: the func3 op encodings, the M-type func7 value, and FSM state encodings.
- One natural sub-module, `muldiv_sign_fix`. It is combinational and handles abs-value pre-processing and conditional negation/selection post-processing, parametrised by `WIDTH`.
- The FSM, iteration counter (`$clog2(WIDTH+1)` bits) and the shared shift/add/subtract datapath stay in `muldiv_unit`.

## Test plan
All scenarios use `WIDTH`=32.
- MUL 7 × 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB; `busy` in cycles 1–32; `done` in cycle 33 only.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division and remainder:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with `done` in cycle 1 and `busy` never high.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; `done` in cycle 1.
- Control boundaries:
  - `start` with new operands in cycle 5 of CALC is ignored; the original result is returned.
  - `rst` in cycle 10 of CALC → next cycle `busy` 0, `result` 0, and no `done` pulse ever.

Source files
------------

// File: rtl/riscv_m_defs.sv
// Shared M-extension definitions: func3 op codes, M-type func7 and FSM states.
package riscv_m_defs;

    localparam logic [6:0] FUNC7_M   = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction before iteration and sign restoration / result
// selection after it. Purely combinational.
module muldiv_sign_fix
    import riscv_m_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         func3_i,
    input  logic [WIDTH-1:0]   op_a_i,
    input  logic [WIDTH-1:0]   op_b_i,
    output logic [WIDTH-1:0]   mag_a_o,
    output logic [WIDTH-1:0]   mag_b_o,
    output logic               sign_a_o,
    output logic               sign_b_o,
    input  logic [2:0]         op_sel_i,
    input  logic               neg_a_i,
    input  logic               neg_b_i,
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   quot_i,
    input  logic [WIDTH-1:0]   rem_i,
    output logic [WIDTH-1:0]   res_o
);

    logic [2*WIDTH-1:0] prod_fix;

    // Signs only count for operands the op treats as signed; magnitudes follow.
    always_comb begin
        sign_a_o = a_is_signed(func3_i) & op_a_i[WIDTH-1];
        sign_b_o = b_is_signed(func3_i) & op_b_i[WIDTH-1];
        mag_a_o  = sign_a_o ? -op_a_i : op_a_i;
        mag_b_o  = sign_b_o ? -op_b_i : op_b_i;
    end

    // Full product is negated before the high half is picked so borrows propagate.
    always_comb begin
        prod_fix = (neg_a_i ^ neg_b_i) ? -prod_i : prod_i;
        res_o    = '0;
        case (op_sel_i)
            F3_MUL:                        res_o = prod_fix[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  res_o = prod_fix[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:               res_o = (neg_a_i ^ neg_b_i) ? -quot_i : quot_i;
            default:                       res_o = neg_a_i ? -rem_i : rem_i;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, sharing one accumulator and operand register.
module muldiv_unit
    import riscv_m_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           func3_q, func3_d;
    logic                 sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]     opr_q, opr_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [WIDTH-1:0]     mag_a, mag_b, fixed_res;
    logic                 sign_a, sign_b;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_rem_next;
    logic [2*WIDTH-1:0]   div_acc_next;
    logic                 div_zero, div_ovf;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .func3_i  (func3),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .mag_a_o  (mag_a),
        .mag_b_o  (mag_b),
        .sign_a_o (sign_a),
        .sign_b_o (sign_b),
        .op_sel_i (func3_q),
        .neg_a_i  (sign_a_q),
        .neg_b_i  (sign_b_q),
        .prod_i   (mul_next),
        .quot_i   (div_acc_next[WIDTH-1:0]),
        .rem_i    (div_rem_next),
        .res_o    (fixed_res)
    );

    // One iteration of each algorithm; the FSM picks which one is committed.
    // Multiply: multiplier sits in the low half and shifts out LSB-first.
    // Divide: dividend sits in the low half and shifts out MSB-first into the
    // WIDTH+1-bit partial remainder; quotient bits shift in at the bottom.
    always_comb begin
        mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
        mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift    = {rem_q, acc_q[WIDTH-1]};
        div_ok       = (div_shift >= {1'b0, opr_q});
        div_rem_next = div_ok ? (div_shift[WIDTH-1:0] - opr_q) : div_shift[WIDTH-1:0];
        div_acc_next = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
        div_zero     = op_is_div(func3) && (op_b == '0);
        div_ovf      = op_is_div(func3) && b_is_signed(func3) && (op_a == MOST_NEG) && (op_b == '1);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opr_d    = opr_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    func3_d  = func3;
                    sign_a_d = sign_a;
                    sign_b_d = sign_b;
                    cnt_d    = CNT_LOAD;
                    rem_d    = '0;
                    if (op_is_div(func3)) begin
                        opr_d = mag_b;
                        acc_d = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opr_d = mag_a;
                        acc_d = {{WIDTH{1'b0}}, mag_b};
                    end
                    if (div_zero) begin
                        result_d = op_is_rem(func3) ? op_a : '1;
                        state_d  = ST_DONE;
                    end else if (div_ovf) begin
                        result_d = op_is_rem(func3) ? '0 : op_a;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (op_is_div(func3_q)) begin
                    acc_d = div_acc_next;
                    rem_d = div_rem_next;
                end else begin
                    acc_d = mul_next;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = fixed_res;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            func3_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opr_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opr_q    <= opr_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_CALC);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule
